// File: rtl/bus_datapath_pkg.sv
// Shared types and constants for the single-bus datapath.
// Special bus sources sit above the GPRs in the select vector, in the order below.
package bus_datapath_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE    = 2'd0,
    MEM_RD_WAIT = 2'd1,
    MEM_WR_WAIT = 2'd2
  } mem_state_t;

  localparam int NUM_SPECIAL = 8;

  // Offsets of the special sources, relative to the first slot after the GPRs
  localparam int SEL_HI     = 0;
  localparam int SEL_LO     = 1;
  localparam int SEL_ZHI    = 2;
  localparam int SEL_ZLO    = 3;
  localparam int SEL_PC     = 4;
  localparam int SEL_MDR    = 5;
  localparam int SEL_INPORT = 6;
  localparam int SEL_C      = 7;

endpackage

// File: rtl/bus_mux_onehot.sv
// N-input priority mux for a nominally one-hot select; the lowest asserted index wins.
// multi flags any cycle in which more than one select is high.
module bus_mux_onehot #(
  parameter int N = 2,
  parameter int W = 32
) (
  input  logic [N-1:0]        sel,
  input  logic [N-1:0][W-1:0] data,
  output logic [W-1:0]        y,
  output logic                multi
);

  always_comb begin
    y = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (sel[i]) y = data[i];
    end
  end

  // Clearing the lowest set bit leaves something only if two or more bits were set
  assign multi = |(sel & (sel - N'(1)));

endmodule

// File: rtl/bus_datapath.sv
// Single-bus CPU datapath: GPR file, special registers, bus mux with contention
// detection, and a wait-state memory sequencer that feeds MDR.
module bus_datapath
  import bus_datapath_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_GPR = 16,
  parameter int ADDR_W  = 9,
  parameter int IMM_W   = 19,
  parameter int MEM_TO  = 15
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [NUM_GPR-1:0]    gpr_out,
  input  logic [NUM_GPR-1:0]    gpr_in,
  input  logic                  hi_out,
  input  logic                  lo_out,
  input  logic                  zhi_out,
  input  logic                  zlo_out,
  input  logic                  pc_out,
  input  logic                  mdr_out,
  input  logic                  inport_out,
  input  logic                  c_out,
  input  logic                  hi_in,
  input  logic                  lo_in,
  input  logic                  z_in,
  input  logic                  pc_in,
  input  logic                  inc_pc,
  input  logic                  ir_in,
  input  logic                  y_in,
  input  logic                  mar_in,
  input  logic                  mdr_in,
  input  logic                  outport_in,
  input  logic [2*DATA_W-1:0]   alu_result,
  input  logic [DATA_W-1:0]     inport_data,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  err_clr,
  output logic [DATA_W-1:0]     bus_contents,
  output logic [DATA_W-1:0]     y_q,
  output logic [DATA_W-1:0]     ir_q,
  output logic [DATA_W-1:0]     outport_q,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  busy,
  output logic                  mem_done,
  output logic                  bus_err,
  output logic                  mem_err
);

  localparam int NUM_SEL = NUM_GPR + NUM_SPECIAL;
  localparam int CNT_W   = $clog2(MEM_TO + 1);

  logic [DATA_W-1:0] gpr [NUM_GPR];
  logic [DATA_W-1:0] hi, lo, z_hi, z_lo, pc, mdr, inport_q, c_ext;
  logic [ADDR_W-1:0] mar;

  logic [NUM_SEL-1:0]             bus_sel;
  logic [NUM_SEL-1:0][DATA_W-1:0] bus_data;
  logic                           bus_multi;

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             finish, timeout, rd_load;

  assign c_ext = {{(DATA_W - IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};

  assign bus_sel = {c_out, inport_out, mdr_out, pc_out, zlo_out, zhi_out, lo_out, hi_out, gpr_out};

  always_comb begin
    for (int g = 0; g < NUM_GPR; g++) bus_data[g] = gpr[g];
    bus_data[NUM_GPR + SEL_HI]     = hi;
    bus_data[NUM_GPR + SEL_LO]     = lo;
    bus_data[NUM_GPR + SEL_ZHI]    = z_hi;
    bus_data[NUM_GPR + SEL_ZLO]    = z_lo;
    bus_data[NUM_GPR + SEL_PC]     = pc;
    bus_data[NUM_GPR + SEL_MDR]    = mdr;
    bus_data[NUM_GPR + SEL_INPORT] = inport_q;
    bus_data[NUM_GPR + SEL_C]      = c_ext;
  end

  bus_mux_onehot #(.N(NUM_SEL), .W(DATA_W)) u_bus_mux (
    .sel   (bus_sel),
    .data  (bus_data),
    .y     (bus_contents),
    .multi (bus_multi)
  );

  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int g = 0; g < NUM_GPR; g++) gpr[g] <= '0;
      hi <= '0; lo <= '0; z_hi <= '0; z_lo <= '0; pc <= '0;
      ir_q <= '0; y_q <= '0; mar <= '0; outport_q <= '0; inport_q <= '0;
    end else begin
      for (int g = 0; g < NUM_GPR; g++) if (gpr_in[g]) gpr[g] <= bus_contents;
      if (hi_in)      hi        <= bus_contents;
      if (lo_in)      lo        <= bus_contents;
      if (z_in)       {z_hi, z_lo} <= alu_result;
      if (pc_in)      pc        <= bus_contents;
      else if (inc_pc) pc       <= pc + DATA_W'(1);
      if (ir_in)      ir_q      <= bus_contents;
      if (y_in)       y_q       <= bus_contents;
      if (mar_in)     mar       <= bus_contents[ADDR_W-1:0];
      if (outport_in) outport_q <= bus_contents;
      inport_q <= inport_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    finish  = 1'b0;
    timeout = 1'b0;
    rd_load = 1'b0;
    unique case (state_q)
      MEM_IDLE: begin
        cnt_d = '0;
        if (mem_rd)      state_d = MEM_RD_WAIT;
        else if (mem_wr) state_d = MEM_WR_WAIT;
      end
      MEM_RD_WAIT, MEM_WR_WAIT: begin
        if (mem_ack) begin
          state_d = MEM_IDLE;
          cnt_d   = '0;
          finish  = 1'b1;
          rd_load = (state_q == MEM_RD_WAIT);
        end else if (cnt_q == CNT_W'(MEM_TO)) begin
          state_d = MEM_IDLE;
          cnt_d   = '0;
          finish  = 1'b1;
          timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = MEM_IDLE;
    endcase
    mem_req = (state_q != MEM_IDLE);
    mem_we  = (state_q == MEM_WR_WAIT);
    busy    = (state_q != MEM_IDLE);
  end

  // A set event in the same cycle as err_clr keeps the sticky flag high
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q  <= MEM_IDLE;
      cnt_q    <= '0;
      mem_done <= 1'b0;
      mem_err  <= 1'b0;
      bus_err  <= 1'b0;
      mdr      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mem_done <= finish;
      if (timeout)      mem_err <= 1'b1;
      else if (err_clr) mem_err <= 1'b0;
      if (bus_multi)    bus_err <= 1'b1;
      else if (err_clr) bus_err <= 1'b0;
      if (rd_load)      mdr <= mem_rdata;
      else if (mdr_in)  mdr <= bus_contents;
    end
  end

  assign mem_addr  = mar;
  assign mem_wdata = mdr;

endmodule

// File: tb/tb_bus_datapath.sv
// Scoreboard bench for bus_datapath: directed stimulus queues expectations,
// negedge monitors compare them and check every memory completion pulse.
module tb_bus_datapath;

  localparam int DATA_W  = 32;
  localparam int NUM_GPR = 16;
  localparam int ADDR_W  = 9;
  localparam int IMM_W   = 19;
  localparam int MEM_TO  = 15;

  localparam int S_BUS = 0, S_Y = 1, S_IR = 2, S_OUTP = 3, S_REQ = 4, S_WE = 5, S_ADDR = 6;
  localparam int S_WDATA = 7, S_BUSY = 8, S_DONE = 9, S_BERR = 10, S_MERR = 11;

  logic clk = 1'b0, clr;
  logic [NUM_GPR-1:0] gpr_out, gpr_in;
  logic hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out;
  logic hi_in, lo_in, z_in, pc_in, inc_pc, ir_in, y_in, mar_in, mdr_in, outport_in;
  logic [2*DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] inport_data, mem_rdata;
  logic mem_rd, mem_wr, mem_ack, err_clr;
  logic [DATA_W-1:0] bus_contents, y_q, ir_q, outport_q, mem_wdata;
  logic mem_req, mem_we, busy, mem_done, bus_err, mem_err;
  logic [ADDR_W-1:0] mem_addr;

  typedef struct { string name; int sig; logic [63:0] exp; } chk_t;
  typedef struct { logic [DATA_W-1:0] mdr; logic err; } done_t;
  chk_t  chk_q[$];
  done_t done_q[$];
  int errors = 0, checks = 0;
  logic armed = 1'b0;

  bus_datapath #(.DATA_W(DATA_W), .NUM_GPR(NUM_GPR), .ADDR_W(ADDR_W), .IMM_W(IMM_W), .MEM_TO(MEM_TO)) dut (
    .clk(clk), .clr(clr), .gpr_out(gpr_out), .gpr_in(gpr_in),
    .hi_out(hi_out), .lo_out(lo_out), .zhi_out(zhi_out), .zlo_out(zlo_out),
    .pc_out(pc_out), .mdr_out(mdr_out), .inport_out(inport_out), .c_out(c_out),
    .hi_in(hi_in), .lo_in(lo_in), .z_in(z_in), .pc_in(pc_in), .inc_pc(inc_pc),
    .ir_in(ir_in), .y_in(y_in), .mar_in(mar_in), .mdr_in(mdr_in), .outport_in(outport_in),
    .alu_result(alu_result), .inport_data(inport_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err_clr(err_clr),
    .bus_contents(bus_contents), .y_q(y_q), .ir_q(ir_q), .outport_q(outport_q),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .mem_done(mem_done), .bus_err(bus_err), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] sample(input int sig);
    case (sig)
      S_BUS:   return 64'(bus_contents);
      S_Y:     return 64'(y_q);
      S_IR:    return 64'(ir_q);
      S_OUTP:  return 64'(outport_q);
      S_REQ:   return 64'(mem_req);
      S_WE:    return 64'(mem_we);
      S_ADDR:  return 64'(mem_addr);
      S_WDATA: return 64'(mem_wdata);
      S_BUSY:  return 64'(busy);
      S_DONE:  return 64'(mem_done);
      S_BERR:  return 64'(bus_err);
      default: return 64'(mem_err);
    endcase
  endfunction

  // Monitor: drains queued checks and matches each completion pulse to an expected access
  always @(negedge clk) begin
    chk_t c;
    done_t d;
    logic [63:0] act;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      act = sample(c.sig);
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", c.name, act, c.exp);
      end
    end
    if (armed && mem_done === 1'b1) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_mem_done: got 1 expected 0");
      end else begin
        d = done_q.pop_front();
        if (mem_wdata !== d.mdr || mem_err !== d.err) begin
          errors++;
          $display("[TB] FAIL mem_done_data: got mdr=%h err=%b expected mdr=%h err=%b",
                   mem_wdata, mem_err, d.mdr, d.err);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int sig, input logic [63:0] exp);
    chk_t c;
    c.name = name; c.sig = sig; c.exp = exp;
    chk_q.push_back(c);
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_done(input logic [DATA_W-1:0] mdr, input logic err);
    done_t d;
    d.mdr = mdr; d.err = err;
    done_q.push_back(d);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    gpr_out = '0; gpr_in = '0;
    {hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out} = '0;
    {hi_in, lo_in, z_in, pc_in, inc_pc, ir_in, y_in, mar_in, mdr_in, outport_in} = '0;
    {mem_rd, mem_wr, mem_ack, err_clr} = '0;
  endtask

  // The inport register reloads every cycle, so it doubles as a way to place any value on the bus
  task automatic put_on_bus(input logic [DATA_W-1:0] v);
    inport_data = v;
    step();
    inport_out = 1'b1;
  endtask

  initial begin
    int cnt;
    applyStimulus();
    alu_result = '0; inport_data = '0; mem_rdata = '0;
    clr = 1'b0;
    step();
    armed = 1'b1;
    step();
    clr = 1'b1;

    put_on_bus(32'hA5A5A5A5); gpr_in[3] = 1'b1; step(); applyStimulus();
    gpr_out[3] = 1'b1;
    checkOutput("gpr3_loaded", S_BUS, 64'hA5A5A5A5);
    step(); applyStimulus();
    inport_data = '0;
    clr = 1'b0; step(); clr = 1'b1;
    gpr_out[3] = 1'b1;
    checkOutput("reset_gpr3", S_BUS, 0);
    checkOutput("reset_y", S_Y, 0);
    checkOutput("reset_ir", S_IR, 0);
    checkOutput("reset_outport", S_OUTP, 0);
    checkOutput("reset_req", S_REQ, 0);
    checkOutput("reset_we", S_WE, 0);
    checkOutput("reset_addr", S_ADDR, 0);
    checkOutput("reset_wdata", S_WDATA, 0);
    checkOutput("reset_busy", S_BUSY, 0);
    checkOutput("reset_done", S_DONE, 0);
    checkOutput("reset_bus_err", S_BERR, 0);
    checkOutput("reset_mem_err", S_MERR, 0);
    step(); applyStimulus();
    checkOutput("idle_bus_zero", S_BUS, 0);

    put_on_bus(32'h10); pc_in = 1'b1; step(); applyStimulus();
    pc_out = 1'b1; gpr_in[5] = 1'b1;
    checkOutput("pc_on_bus", S_BUS, 64'h10);
    step(); applyStimulus();
    gpr_out[5] = 1'b1;
    checkOutput("gpr5_from_pc", S_BUS, 64'h10);
    step(); applyStimulus();
    inc_pc = 1'b1; step(); applyStimulus();
    pc_out = 1'b1;
    checkOutput("pc_inc", S_BUS, 64'h11);
    step(); applyStimulus();
    put_on_bus(32'hFFFFFFFF); pc_in = 1'b1; step(); applyStimulus();
    inc_pc = 1'b1; step(); applyStimulus();
    pc_out = 1'b1;
    checkOutput("pc_wrap", S_BUS, 0);
    step(); applyStimulus();
    put_on_bus(32'h20); pc_in = 1'b1; inc_pc = 1'b1; step(); applyStimulus();
    pc_out = 1'b1;
    checkOutput("pc_in_beats_inc", S_BUS, 64'h20);
    step(); applyStimulus();

    put_on_bus(32'h0BADF00D); y_in = 1'b1; outport_in = 1'b1; step(); applyStimulus();
    checkOutput("y_load", S_Y, 64'h0BADF00D);
    checkOutput("outport_load", S_OUTP, 64'h0BADF00D);

    put_on_bus(32'h1234); gpr_in[2] = 1'b1; step(); applyStimulus();
    put_on_bus(32'h5555); hi_in = 1'b1; step(); applyStimulus();
    hi_out = 1'b1;
    checkOutput("hi_on_bus", S_BUS, 64'h5555);
    checkOutput("single_select_no_err", S_BERR, 0);
    step(); applyStimulus();
    gpr_out[2] = 1'b1; hi_out = 1'b1;
    checkOutput("contention_priority", S_BUS, 64'h1234);
    step(); applyStimulus();
    checkOutput("bus_err_set", S_BERR, 1);
    step();
    checkOutput("bus_err_held", S_BERR, 1);
    err_clr = 1'b1; step(); applyStimulus();
    checkOutput("bus_err_cleared", S_BERR, 0);
    gpr_out[2] = 1'b1; hi_out = 1'b1; err_clr = 1'b1; step(); applyStimulus();
    checkOutput("bus_err_set_beats_clr", S_BERR, 1);
    pc_out = 1'b1; mdr_out = 1'b1;
    checkOutput("pc_beats_mdr", S_BUS, 64'h20);
    err_clr = 1'b1; step(); applyStimulus();

    put_on_bus(32'h00040000); ir_in = 1'b1; step(); applyStimulus();
    checkOutput("ir_load", S_IR, 64'h00040000);
    c_out = 1'b1;
    checkOutput("c_sign_ext_neg", S_BUS, 64'hFFFC0000);
    step(); applyStimulus();
    put_on_bus(32'hFFF3FFFF); ir_in = 1'b1; step(); applyStimulus();
    c_out = 1'b1;
    checkOutput("c_sign_ext_pos", S_BUS, 64'h0003FFFF);
    step(); applyStimulus();
    alu_result = 64'h1_00000002; z_in = 1'b1; step(); applyStimulus();
    zhi_out = 1'b1;
    checkOutput("z_hi", S_BUS, 64'h1);
    step(); applyStimulus();
    zlo_out = 1'b1;
    checkOutput("z_lo", S_BUS, 64'h2);
    step(); applyStimulus();

    put_on_bus(32'h1F); mar_in = 1'b1; step(); applyStimulus();
    checkOutput("mar_addr", S_ADDR, 64'h1F);
    expect_done(32'hDEADBEEF, 1'b0);
    mem_rd = 1'b1; step(); applyStimulus();
    checkOutput("rd_req", S_REQ, 1);
    checkOutput("rd_we", S_WE, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("rd_busy", S_BUSY, 1);
      if (i == 3) begin
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        mdr_in = 1'b1; inport_out = 1'b1;
      end
      step(); applyStimulus();
    end
    checkOutput("rd_busy_end", S_BUSY, 0);
    checkOutput("rd_mdr", S_WDATA, 64'hDEADBEEF);
    checkOutput("rd_done_pulse", S_DONE, 1);
    step();
    checkOutput("rd_done_single", S_DONE, 0);

    expect_done(32'hDEADBEEF, 1'b1);
    mem_wr = 1'b1; step(); applyStimulus();
    checkOutput("wr_req", S_REQ, 1);
    checkOutput("wr_we", S_WE, 1);
    cnt = 0;
    while (mem_done !== 1'b1 && cnt < MEM_TO + 10) begin
      if (cnt == 2) mem_rd = 1'b1;
      step();
      mem_rd = 1'b0;
      cnt++;
    end
    check_val("timeout_latency", cnt, MEM_TO + 1);
    checkOutput("timeout_mem_err", S_MERR, 1);
    checkOutput("timeout_idle", S_BUSY, 0);
    step();
    checkOutput("busy_rd_ignored", S_BUSY, 0);
    checkOutput("timeout_err_held", S_MERR, 1);
    err_clr = 1'b1; step(); applyStimulus();
    checkOutput("mem_err_cleared", S_MERR, 0);

    expect_done(32'hCAFEF00D, 1'b0);
    mem_rd = 1'b1; mem_wr = 1'b1; step(); applyStimulus();
    checkOutput("rdwr_req", S_REQ, 1);
    checkOutput("rdwr_is_read", S_WE, 0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D; step(); applyStimulus();
    checkOutput("rdwr_mdr", S_WDATA, 64'hCAFEF00D);
    step();
    mem_ack = 1'b1; mem_rdata = 32'h11111111; step(); applyStimulus();
    checkOutput("idle_ack_ignored_mdr", S_WDATA, 64'hCAFEF00D);
    checkOutput("idle_ack_no_done", S_DONE, 0);

    mem_rd = 1'b1; step(); applyStimulus();
    checkOutput("abort_busy", S_BUSY, 1);
    step();
    clr = 1'b0; step(); clr = 1'b1;
    checkOutput("abort_idle", S_BUSY, 0);
    checkOutput("abort_no_req", S_REQ, 0);
    checkOutput("abort_mdr_reset", S_WDATA, 0);
    mem_ack = 1'b1; mem_rdata = 32'h22222222; step(); applyStimulus();
    checkOutput("abort_no_done", S_DONE, 0);
    step(); step();
    check_val("scoreboard_drain", done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
